// File: rtl/sdf_delay_buffer.sv
// Complex delay line for SDF FFT feedback paths: a circular array of storage
// entries with a wrapping pointer, run-time depth, valid tracking and flush.

module sdf_delay_entry #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [WIDTH-1:0] d_re,
    input  logic [WIDTH-1:0] d_im,
    output logic [WIDTH-1:0] q_re,
    output logic [WIDTH-1:0] q_im
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_re <= '0;
            q_im <= '0;
        end else if (we) begin
            q_re <= d_re;
            q_im <= d_im;
        end
    end

endmodule

module sdf_delay_buffer #(
    parameter int WIDTH     = 12,
    parameter int MAX_DEPTH = 8,
    parameter int DW        = $clog2(MAX_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    flush,
    input  logic [DW-1:0]           cfg_depth,
    input  logic signed [WIDTH-1:0] din_re,
    input  logic signed [WIDTH-1:0] din_im,
    output logic signed [WIDTH-1:0] dout_re,
    output logic signed [WIDTH-1:0] dout_im,
    output logic                    dout_vld
);

    localparam int PW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

    typedef struct packed {
        logic [WIDTH-1:0] re;
        logic [WIDTH-1:0] im;
    } sample_t;

    logic [DW-1:0] depth;
    logic [DW-1:0] fill;
    logic [PW-1:0] ptr;
    logic          adv;
    logic          ptr_last;
    sample_t       rd;

    logic [MAX_DEPTH-1:0][WIDTH-1:0] q_re;
    logic [MAX_DEPTH-1:0][WIDTH-1:0] q_im;

    function automatic logic [DW-1:0] clamp_depth(input logic [DW-1:0] c);
        if (c == '0)
            return DW'(1);
        else if (c > DW'(MAX_DEPTH))
            return DW'(MAX_DEPTH);
        else
            return c;
    endfunction

    assign adv      = en & ~flush;
    assign ptr_last = (DW'(ptr) == depth - DW'(1));

    // Only the entry under the pointer is written; its old value is read out
    // the same cycle, which gives the read-before-write delay behaviour.
    for (genvar i = 0; i < MAX_DEPTH; i++) begin : g_entry
        sdf_delay_entry #(.WIDTH(WIDTH)) u_entry (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (adv && (ptr == PW'(i))),
            .d_re  (din_re),
            .d_im  (din_im),
            .q_re  (q_re[i]),
            .q_im  (q_im[i])
        );
    end

    always_comb begin
        rd = '0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            if (ptr == PW'(i)) begin
                rd.re = q_re[i];
                rd.im = q_im[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth <= DW'(MAX_DEPTH);
            ptr   <= '0;
            fill  <= '0;
        end else if (flush) begin
            depth <= clamp_depth(cfg_depth);
            ptr   <= '0;
            fill  <= '0;
        end else if (en) begin
            ptr  <= ptr_last ? '0 : ptr + PW'(1);
            fill <= (fill == depth) ? depth : fill + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_re  <= '0;
            dout_im  <= '0;
            dout_vld <= 1'b0;
        end else if (flush) begin
            dout_re  <= '0;
            dout_im  <= '0;
            dout_vld <= 1'b0;
        end else if (en) begin
            dout_re  <= rd.re;
            dout_im  <= rd.im;
            dout_vld <= (fill == depth);
        end
    end

endmodule

// File: tb/tb_sdf_delay_buffer.sv
// Directed bench for sdf_delay_buffer; a FIFO scoreboard of written samples
// produces the expected output once more than D samples are queued.

module tb_sdf_delay_buffer;

    localparam int WIDTH     = 12;
    localparam int MAX_DEPTH = 8;
    localparam int DW        = $clog2(MAX_DEPTH + 1);

    typedef struct {
        logic [WIDTH-1:0] re;
        logic [WIDTH-1:0] im;
    } smp_t;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    en;
    logic                    flush;
    logic [DW-1:0]           cfg_depth;
    logic signed [WIDTH-1:0] din_re;
    logic signed [WIDTH-1:0] din_im;
    logic signed [WIDTH-1:0] dout_re;
    logic signed [WIDTH-1:0] dout_im;
    logic                    dout_vld;

    sdf_delay_buffer #(.WIDTH(WIDTH), .MAX_DEPTH(MAX_DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .flush     (flush),
        .cfg_depth (cfg_depth),
        .din_re    (din_re),
        .din_im    (din_im),
        .dout_re   (dout_re),
        .dout_im   (dout_im),
        .dout_vld  (dout_vld)
    );

    always #5 clk = ~clk;

    int               checks = 0;
    int               errors = 0;
    smp_t             sb[$];
    int               mdl_d;
    logic             exp_vld;
    logic             exp_known;
    logic [WIDTH-1:0] exp_re;
    logic [WIDTH-1:0] exp_im;

    task automatic check(input string tag);
        checks++;
        assert (dout_vld === exp_vld) else begin
            errors++;
            $error("FAIL %s vld: got %b want %b", tag, dout_vld, exp_vld);
        end
        if (exp_known) begin
            checks++;
            assert (dout_re === exp_re) else begin
                errors++;
                $error("FAIL %s re: got %0d want %0d", tag, dout_re, $signed(exp_re));
            end
            checks++;
            assert (dout_im === exp_im) else begin
                errors++;
                $error("FAIL %s im: got %0d want %0d", tag, dout_im, $signed(exp_im));
            end
        end
    endtask

    function automatic int clamp(input int c);
        if (c == 0) return 1;
        if (c > MAX_DEPTH) return MAX_DEPTH;
        return c;
    endfunction

    task automatic model_reset();
        sb.delete();
        mdl_d     = MAX_DEPTH;
        exp_vld   = 1'b0;
        exp_known = 1'b1;
        exp_re    = '0;
        exp_im    = '0;
    endtask

    // One clock: drive on the falling edge, update the model and check 1ns after the rising edge.
    task automatic step(input logic e, input logic f, input int c,
                        input int re, input int im, input string tag);
        smp_t s;
        @(negedge clk);
        en        = e;
        flush     = f;
        cfg_depth = DW'(c);
        din_re    = WIDTH'(re);
        din_im    = WIDTH'(im);
        @(posedge clk);
        #1;
        if (f) begin
            sb.delete();
            mdl_d     = clamp(c);
            exp_vld   = 1'b0;
            exp_known = 1'b1;
            exp_re    = '0;
            exp_im    = '0;
        end else if (e) begin
            s.re = WIDTH'(re);
            s.im = WIDTH'(im);
            sb.push_back(s);
            if (sb.size() > mdl_d) begin
                s         = sb.pop_front();
                exp_vld   = 1'b1;
                exp_known = 1'b1;
                exp_re    = s.re;
                exp_im    = s.im;
            end else begin
                exp_vld   = 1'b0;
                exp_known = 1'b0;
            end
        end
        check(tag);
    endtask

    initial begin
        int pat[7];
        int k;
        rst_n = 1'b0; en = 1'b0; flush = 1'b0; cfg_depth = '0; din_re = '0; din_im = '0;
        model_reset();
        #12;
        check("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 0, 0, 0, "idle");

        // Depth 4, continuous enable, vld rises on the 5th en
        step(1'b0, 1'b1, 4, 0, 0, "flush4");
        for (int i = 1; i <= 12; i++) step(1'b1, 1'b0, 0, i, -i, "d4");

        // Depth 3 with stalls; 10 emerges on the 4th en
        step(1'b0, 1'b1, 3, 0, 0, "flush3");
        pat = '{1, 0, 0, 1, 1, 0, 1};
        k = 10;
        for (int i = 0; i < 7; i++) begin
            step(pat[i][0], 1'b0, 0, k, k + 100, "stall");
            if (pat[i] == 1) k++;
        end
        step(1'b0, 1'b0, 7, 99, 99, "hold");
        step(1'b0, 1'b0, 7, 98, 98, "hold");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 0, 20 + i, 30 + i, "stall_tail");

        // Depth clamping at both ends
        step(1'b0, 1'b1, 0, 0, 0, "flush0");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 0, 40 + i, -40 - i, "d1");
        step(1'b0, 1'b1, 15, 0, 0, "flush15");
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 0, 50 + i, 60 + i, "d8");

        // Flush together with en drops the presented sample
        step(1'b0, 1'b1, 4, 0, 0, "flush4b");
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 0, 70 + i, 7 + i, "pre");
        step(1'b1, 1'b1, 4, 77, 77, "flush_en");
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 0, 80 + i, 8 + i, "post");

        // Signed extremes pass bit-exact
        step(1'b0, 1'b1, 2, 0, 0, "flush2");
        step(1'b1, 1'b0, 0, -2048, 2047, "ext");
        step(1'b1, 1'b0, 0, 2047, -2048, "ext");
        step(1'b1, 1'b0, 0, -1, 0, "ext");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, i, i, "ext_tail");

        // Async reset between edges clears outputs without a clock
        @(negedge clk);
        en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 0, 200 + i, -200 - i, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
